// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid instruction-memory port and presents PC/instruction to decode.
module if_fetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            ID_Stall,
  input  logic            EX_Redirect,
  input  logic [XLEN-1:0] EX_Redirect_PC,
  output logic            IMem_req,
  output logic [XLEN-1:0] IMem_addr,
  input  logic            IMem_gnt,
  input  logic            IMem_rvalid,
  input  logic [XLEN-1:0] IMem_rdata,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_Instruction,
  output logic            IF_Valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] a);
    return a + PC_STEP;
  endfunction

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            grant;
  logic            resp;

  logic [XLEN-1:0] req_pc_p0;
  logic            buf_vld_p1;
  logic [XLEN-1:0] buf_pc_p1;
  logic [XLEN-1:0] buf_instr_p1;

  assign IMem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    IMem_req   = 1'b0;

    case (state_q)
      S_REQ:   IMem_req = !buf_vld_p1 && !EX_Redirect && !Reset;
      S_WAIT:  IMem_req = IMem_rvalid && !ID_Stall && !buf_vld_p1 && !EX_Redirect && !Reset;
      default: IMem_req = 1'b0;
    endcase

    grant = IMem_req && IMem_gnt;
    resp  = (state_q == S_WAIT) && IMem_rvalid;

    if (EX_Redirect) begin
      fetch_pc_d = word_align(EX_Redirect_PC);
      // A response landing in the redirect cycle retires the outstanding
      // request, so there is nothing left to drop.
      case (state_q)
        S_WAIT:  state_d = IMem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = IMem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (grant) fetch_pc_d = pc_next(fetch_pc_q);
      case (state_q)
        S_REQ:   if (grant) state_d = S_WAIT;
        S_WAIT:  if (IMem_rvalid) state_d = grant ? S_WAIT : S_REQ;
        S_DROP:  if (IMem_rvalid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Stage p0: request issue / control and decode-facing output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_REQ;
      fetch_pc_q     <= word_align(RESET_PC);
      buf_vld_p1     <= 1'b0;
      IF_Valid       <= 1'b0;
      IF_PC          <= '0;
      IF_Instruction <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (EX_Redirect) begin
        buf_vld_p1     <= 1'b0;
        IF_Valid       <= 1'b0;
        IF_Instruction <= NOP_INSTR;
      end else if (!ID_Stall) begin
        if (buf_vld_p1) begin
          IF_PC          <= buf_pc_p1;
          IF_Instruction <= buf_instr_p1;
          IF_Valid       <= 1'b1;
          buf_vld_p1     <= 1'b0;
        end else if (resp) begin
          IF_PC          <= req_pc_p0;
          IF_Instruction <= IMem_rdata;
          IF_Valid       <= 1'b1;
        end else begin
          IF_Instruction <= NOP_INSTR;
          IF_Valid       <= 1'b0;
        end
      end else if (resp) begin
        buf_vld_p1 <= 1'b1;
      end
    end
  end

  // Stage p1: request PC capture and one-entry skid buffer data
  always_ff @(posedge Clk) begin
    if (grant) req_pc_p0 <= fetch_pc_q;
    if (resp && ID_Stall && !EX_Redirect) begin
      buf_pc_p1    <= req_pc_p0;
      buf_instr_p1 <= IMem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with a configurable-latency memory responder.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ID_Stall = 1'b0;
  logic        EX_Redirect = 1'b0;
  logic [31:0] EX_Redirect_PC = 32'h0;
  logic        IMem_req;
  logic [31:0] IMem_addr;
  logic        IMem_gnt = 1'b0;
  logic        IMem_rvalid = 1'b0;
  logic [31:0] IMem_rdata = 32'h0;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_Valid;

  int checks = 0;
  int errors = 0;

  int lat = 1;
  int gnt_wait = 0;

  logic        hs_seen = 1'b0;
  logic        rst_seen = 1'b1;
  logic [31:0] hs_addr = 32'h0;
  logic [31:0] resp_addr = 32'h0;
  int          cnt = 0;
  int          wait_cnt = 0;

  if_fetch #(.XLEN(32), .RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ID_Stall(ID_Stall),
    .EX_Redirect(EX_Redirect),
    .EX_Redirect_PC(EX_Redirect_PC),
    .IMem_req(IMem_req),
    .IMem_addr(IMem_addr),
    .IMem_gnt(IMem_gnt),
    .IMem_rvalid(IMem_rvalid),
    .IMem_rdata(IMem_rdata),
    .IF_PC(IF_PC),
    .IF_Instruction(IF_Instruction),
    .IF_Valid(IF_Valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: handshake observed mid-cycle, response lat cycles later.
  always @(negedge Clk) begin
    rst_seen = Reset;
    hs_seen  = IMem_req && IMem_gnt;
    hs_addr  = IMem_addr;
    if (Reset || !IMem_req || IMem_gnt) wait_cnt = 0;
    else wait_cnt = wait_cnt + 1;
  end

  always @(posedge Clk) begin
    #1;
    IMem_rvalid = 1'b0;
    if (rst_seen) cnt = 0;
    else if (hs_seen) begin
      cnt = lat;
      resp_addr = hs_addr;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        IMem_rvalid = 1'b1;
        IMem_rdata  = instr_of(resp_addr);
      end
    end
    IMem_gnt = (wait_cnt >= gnt_wait);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    Reset = 1'b1; ID_Stall = 1'b0; EX_Redirect = 1'b0; EX_Redirect_PC = 32'h0;
    tick();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    tick(); Reset = 1'b1;
    tick(); tick();
    @(negedge Clk);
    checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IF_Valid); end
    checks++; if (IF_Instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", IF_Instruction, NOP); end
    checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", IF_PC); end
    checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", IMem_req); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, ep;
    gnt_wait = 0; lat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      @(negedge Clk);
      ea = 32'h100 + 32'(k * 4);
      checks++;
      if (IMem_req !== 1'b1 || IMem_addr !== ea) begin
        errors++; $display("FAIL b2b_req c%0d got req=%b addr=%h exp req=1 addr=%h", k, IMem_req, IMem_addr, ea);
      end
      checks++;
      if (k >= 2) begin
        ep = 32'h100 + 32'((k - 2) * 4);
        if (IF_Valid !== 1'b1 || IF_PC !== ep || IF_Instruction !== instr_of(ep)) begin
          errors++; $display("FAIL b2b_out c%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", k, IF_Valid, IF_PC, IF_Instruction, ep, instr_of(ep));
        end
      end else if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
        errors++; $display("FAIL b2b_bubble c%0d got v=%b i=%h exp v=0 i=%h", k, IF_Valid, IF_Instruction, NOP);
      end
    end
    tick(); Reset = 1'b1;
    @(negedge Clk);
    checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL midreset_req got %b exp 0", IMem_req); end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b0 || IF_Instruction !== NOP || IF_PC !== 32'h0) begin
      errors++; $display("FAIL midreset_out got v=%b pc=%h i=%h exp v=0 pc=0 i=%h", IF_Valid, IF_PC, IF_Instruction, NOP);
    end
  endtask

  task automatic test_stall();
    gnt_wait = 0; lat = 1;
    do_reset();
    tick();
    tick(); ID_Stall = 1'b1;
    for (int k = 2; k < 6; k++) begin
      if (k > 2) tick();
      if (k == 5) ID_Stall = 1'b0;
      @(negedge Clk);
      checks++;
      if (IMem_req !== 1'b0 || IF_Valid !== 1'b1 || IF_PC !== 32'h100) begin
        errors++; $display("FAIL stall_hold c%0d got req=%b v=%b pc=%h exp req=0 v=1 pc=00000100", k, IMem_req, IF_Valid, IF_PC);
      end
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h104 || IF_Instruction !== instr_of(32'h104)) begin
      errors++; $display("FAIL stall_release got v=%b pc=%h i=%h exp v=1 pc=00000104 i=%h", IF_Valid, IF_PC, IF_Instruction, instr_of(32'h104));
    end
    checks++;
    if (IMem_req !== 1'b1 || IMem_addr !== 32'h108) begin
      errors++; $display("FAIL stall_refetch got req=%b addr=%h exp req=1 addr=00000108", IMem_req, IMem_addr);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
      errors++; $display("FAIL stall_gap got v=%b i=%h exp v=0 i=%h", IF_Valid, IF_Instruction, NOP);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h108) begin
      errors++; $display("FAIL stall_next got v=%b pc=%h exp v=1 pc=00000108", IF_Valid, IF_PC);
    end
  endtask

  task automatic test_redirect_wait();
    gnt_wait = 0; lat = 2;
    do_reset();
    repeat (5) tick();
    EX_Redirect = 1'b1; EX_Redirect_PC = 32'h200;
    @(negedge Clk);
    checks++;
    if (IMem_req !== 1'b0 || IF_Valid !== 1'b1 || IF_PC !== 32'h104) begin
      errors++; $display("FAIL rdw_pre got req=%b v=%b pc=%h exp req=0 v=1 pc=00000104", IMem_req, IF_Valid, IF_PC);
    end
    tick(); EX_Redirect = 1'b0;
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b0 || IF_Instruction !== NOP || IMem_req !== 1'b0) begin
      errors++; $display("FAIL rdw_bubble got v=%b i=%h req=%b exp v=0 i=%h req=0", IF_Valid, IF_Instruction, IMem_req, NOP);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IMem_req !== 1'b1 || IMem_addr !== 32'h200 || IF_Valid !== 1'b0) begin
      errors++; $display("FAIL rdw_target got req=%b addr=%h v=%b exp req=1 addr=00000200 v=0", IMem_req, IMem_addr, IF_Valid);
    end
    for (int k = 8; k < 10; k++) begin
      tick();
      @(negedge Clk);
      checks++;
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL rdw_drop c%0d got v=%b pc=%h exp v=0", k, IF_Valid, IF_PC); end
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h200 || IF_Instruction !== instr_of(32'h200)) begin
      errors++; $display("FAIL rdw_present got v=%b pc=%h i=%h exp v=1 pc=00000200 i=%h", IF_Valid, IF_PC, IF_Instruction, instr_of(32'h200));
    end
  endtask

  task automatic test_redirect_stall();
    gnt_wait = 0; lat = 1;
    do_reset();
    tick();
    tick(); ID_Stall = 1'b1;
    tick(); EX_Redirect = 1'b1; EX_Redirect_PC = 32'h300;
    @(negedge Clk);
    checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL rds_req got %b exp 0", IMem_req); end
    tick(); EX_Redirect = 1'b0; ID_Stall = 1'b0;
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b0 || IMem_req !== 1'b1 || IMem_addr !== 32'h300) begin
      errors++; $display("FAIL rds_restart got v=%b req=%b addr=%h exp v=0 req=1 addr=00000300", IF_Valid, IMem_req, IMem_addr);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
      errors++; $display("FAIL rds_stale got v=%b pc=%h i=%h exp v=0 i=%h", IF_Valid, IF_PC, IF_Instruction, NOP);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h300 || IF_Instruction !== instr_of(32'h300)) begin
      errors++; $display("FAIL rds_target got v=%b pc=%h i=%h exp v=1 pc=00000300 i=%h", IF_Valid, IF_PC, IF_Instruction, instr_of(32'h300));
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h304) begin
      errors++; $display("FAIL rds_next got v=%b pc=%h exp v=1 pc=00000304", IF_Valid, IF_PC);
    end
  endtask

  task automatic test_slow_mem();
    gnt_wait = 2; lat = 3;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      @(negedge Clk);
      if (k <= 2 || k == 5) begin
        checks++;
        if (IMem_req !== 1'b1 || IMem_addr !== (k == 5 ? 32'h104 : 32'h100)) begin
          errors++; $display("FAIL slow_req c%0d got req=%b addr=%h exp req=1", k, IMem_req, IMem_addr);
        end
      end
      if (k == 3 || k == 4) begin
        checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL slow_idle c%0d got req=%b exp 0", k, IMem_req); end
      end
      if (k == 6) begin
        checks++;
        if (IF_Valid !== 1'b1 || IF_PC !== 32'h100 || IMem_req !== 1'b1 || IMem_addr !== 32'h104) begin
          errors++; $display("FAIL slow_first got v=%b pc=%h req=%b addr=%h exp v=1 pc=00000100 req=1 addr=00000104", IF_Valid, IF_PC, IMem_req, IMem_addr);
        end
      end else if (k == 11) begin
        checks++;
        if (IF_Valid !== 1'b1 || IF_PC !== 32'h104 || IF_Instruction !== instr_of(32'h104)) begin
          errors++; $display("FAIL slow_second got v=%b pc=%h i=%h exp v=1 pc=00000104", IF_Valid, IF_PC, IF_Instruction);
        end
      end else begin
        checks++;
        if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
          errors++; $display("FAIL slow_gap c%0d got v=%b i=%h exp v=0 i=%h", k, IF_Valid, IF_Instruction, NOP);
        end
        if (k == 7) begin
          checks++;
          if (IF_PC !== 32'h100 || IMem_req !== 1'b1 || IMem_addr !== 32'h104) begin
            errors++; $display("FAIL slow_hold got pc=%h req=%b addr=%h exp pc=00000100 req=1 addr=00000104", IF_PC, IMem_req, IMem_addr);
          end
        end
      end
    end
  endtask

  task automatic test_align_wrap();
    gnt_wait = 0; lat = 1;
    do_reset();
    EX_Redirect = 1'b1; EX_Redirect_PC = 32'h203;
    @(negedge Clk);
    checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL align_noreq got %b exp 0", IMem_req); end
    tick(); EX_Redirect = 1'b0;
    @(negedge Clk);
    checks++;
    if (IMem_req !== 1'b1 || IMem_addr !== 32'h200) begin
      errors++; $display("FAIL align_addr got req=%b addr=%h exp req=1 addr=00000200", IMem_req, IMem_addr);
    end
    tick(); EX_Redirect = 1'b1; EX_Redirect_PC = 32'hFFFF_FFFE;
    tick(); EX_Redirect = 1'b0;
    @(negedge Clk);
    checks++;
    if (IMem_req !== 1'b1 || IMem_addr !== 32'hFFFF_FFFC || IF_Valid !== 1'b0) begin
      errors++; $display("FAIL wrap_top got req=%b addr=%h v=%b exp req=1 addr=fffffffc v=0", IMem_req, IMem_addr, IF_Valid);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IMem_req !== 1'b1 || IMem_addr !== 32'h0 || IF_Valid !== 1'b0) begin
      errors++; $display("FAIL wrap_zero got req=%b addr=%h v=%b exp req=1 addr=00000000 v=0", IMem_req, IMem_addr, IF_Valid);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_out_top got v=%b pc=%h exp v=1 pc=fffffffc", IF_Valid, IF_PC);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h0 || IF_Instruction !== instr_of(32'h0)) begin
      errors++; $display("FAIL wrap_out_zero got v=%b pc=%h i=%h exp v=1 pc=00000000 i=%h", IF_Valid, IF_PC, IF_Instruction, instr_of(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_slow_mem();
    test_align_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
